// File: rtl/axi_rd_arbiter_if.sv
// Requester-side and memory-side AXI4 read channels of axi_rd_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface axi_rd_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 6
);
  logic [NUM_REQ-1:0]            s_arvalid;
  logic [NUM_REQ-1:0]            s_arready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  s_arlen;
  logic [NUM_REQ-1:0]            s_rvalid;
  logic [NUM_REQ-1:0]            s_rready;
  logic [DATA_WIDTH-1:0]         s_rdata;
  logic                          s_rlast;
  logic [1:0]                    s_rresp;
  logic                          m_arvalid;
  logic                          m_arready;
  logic [ADDR_WIDTH-1:0]         m_araddr;
  logic [LEN_WIDTH-1:0]          m_arlen;
  logic [ID_WIDTH-1:0]           m_arid;
  logic                          m_rvalid;
  logic                          m_rready;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          m_rlast;
  logic [1:0]                    m_rresp;
  logic [ID_WIDTH-1:0]           m_rid;

  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_rready,
    input  m_arready, m_rvalid, m_rdata, m_rlast, m_rresp, m_rid,
    output s_arready, s_rvalid, s_rdata, s_rlast, s_rresp,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  modport master (
    output s_arvalid, s_araddr, s_arlen, s_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast, m_rresp, m_rid,
    input  s_arready, s_rvalid, s_rdata, s_rlast, s_rresp,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_REQ masters; ARID carries the
// requester index, R beats are routed back by RID, and bursts in flight are capped per requester.
module axi_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 4,
  parameter int ID_WIDTH   = 6,
  parameter int MAX_OUTST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arbiter_if.slave  bus,
  output logic             rid_err
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADDR = 1'b1;

  logic [0:0]            state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]      outst_r [NUM_REQ];
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [LEN_WIDTH-1:0]  arlen_r;
  logic [ID_WIDTH-1:0]   arid_r;
  logic                  rid_err_r;

  logic [NUM_REQ-1:0]    eligible_s;
  logic [NUM_REQ-1:0]    arready_s;
  logic [NUM_REQ-1:0]    ar_hs_s;
  logic [NUM_REQ-1:0]    rvalid_s;
  logic [NUM_REQ-1:0]    r_done_s;
  logic                  grant_vld_s;
  logic [IDX_W-1:0]      grant_s;
  logic [IDX_W-1:0]      ridx_s;
  logic                  mapped_s;
  logic                  rready_s;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
    return IDX_W'((int'(ptr) + k) % NUM_REQ);
  endfunction

  // A requester may compete only while it is below its outstanding-burst cap.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = bus.s_arvalid[i] && (outst_r[i] != CNT_W'(MAX_OUTST));
    end
  end

  // Round-robin search from rr_ptr+1; walking downwards lets the nearest candidate win.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      grant_s     = eligible_s[rr_idx(rr_ptr_r, k)] ? rr_idx(rr_ptr_r, k) : grant_s;
      grant_vld_s = grant_vld_s | eligible_s[rr_idx(rr_ptr_r, k)];
    end
  end

  // AR accept pulses only in IDLE, so at most one burst is taken every two cycles.
  always_comb begin
    arready_s = '0;
    if (!rst && (state_r == ST_IDLE) && grant_vld_s) begin
      arready_s[grant_s] = 1'b1;
    end else begin
      arready_s = '0;
    end
  end

  assign ar_hs_s = arready_s & bus.s_arvalid;

  assign ridx_s   = bus.m_rid[IDX_W-1:0];
  assign mapped_s = ((bus.m_rid >> IDX_W) == '0) && (int'(ridx_s) < NUM_REQ);

  // Unmapped beats are drained so a stray RID can never stall the shared R channel.
  always_comb begin
    rvalid_s = '0;
    r_done_s = '0;
    rready_s = 1'b1;
    if (mapped_s) begin
      rvalid_s[ridx_s] = bus.m_rvalid;
      rready_s         = bus.s_rready[ridx_s];
      r_done_s[ridx_s] = bus.m_rvalid && bus.s_rready[ridx_s] && bus.m_rlast;
    end else begin
      rready_s = 1'b1;
    end
  end

  // AR FSM: latch the granted request, then hold it on m_ar* until memory accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= IDX_W'(NUM_REQ - 1);
      araddr_r <= '0;
      arlen_r  <= '0;
      arid_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_vld_s) begin
            araddr_r <= bus.s_araddr[grant_s*ADDR_WIDTH +: ADDR_WIDTH];
            arlen_r  <= bus.s_arlen[grant_s*LEN_WIDTH +: LEN_WIDTH];
            arid_r   <= ID_WIDTH'(grant_s);
            rr_ptr_r <= grant_s;
            state_r  <= ST_ADDR;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (bus.m_arready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Outstanding counters: simultaneous issue and completion cancel; never wraps below zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        outst_r[i] <= '0;
      end else if (ar_hs_s[i] && !r_done_s[i]) begin
        outst_r[i] <= outst_r[i] + CNT_W'(1);
      end else if (r_done_s[i] && !ar_hs_s[i] && (outst_r[i] != '0)) begin
        outst_r[i] <= outst_r[i] - CNT_W'(1);
      end else begin
        outst_r[i] <= outst_r[i];
      end
    end
  end

  // Sticky flag for any beat whose RID does not name a requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_err_r <= 1'b0;
    end else if (bus.m_rvalid && !mapped_s) begin
      rid_err_r <= 1'b1;
    end else begin
      rid_err_r <= rid_err_r;
    end
  end

  assign bus.s_arready = arready_s;
  assign bus.s_rvalid  = rvalid_s;
  assign bus.s_rdata   = bus.m_rdata;
  assign bus.s_rlast   = bus.m_rlast;
  assign bus.s_rresp   = bus.m_rresp;
  assign bus.m_arvalid = (state_r == ST_ADDR);
  assign bus.m_araddr  = araddr_r;
  assign bus.m_arlen   = arlen_r;
  assign bus.m_arid    = arid_r;
  assign bus.m_rready  = rready_s;
  assign rid_err       = rid_err_r;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: requester and memory models drive traffic,
// a negedge monitor compares arbitration, AR forwarding and R routing against queue-based models.
module tb_axi_rd_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int LW   = 4;
  localparam int IW   = 6;
  localparam int MAXO = 4;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; int id; } ar_t;
  typedef struct { logic [DW-1:0] data; logic last; logic [1:0] resp; } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic rid_err;

  axi_rd_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  axi_rd_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                   .ID_WIDTH(IW), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rid_err(rid_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ar_t   exp_ar[$];
  beat_t exp_beat[NREQ][$];
  ar_t   mem_pend[NREQ][$];
  int    beatidx[NREQ];
  int    cnt[NREQ];
  int    last_g;
  bit    busy, err_m, r_hs;
  logic [NREQ-1:0] ar_hs;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a, input int b);
    return {a, 16'hbeef, 16'(b)};
  endfunction

  function automatic logic [1:0] mkresp(input logic [AW-1:0] a, input int b);
    return a[5:4] ^ 2'(b);
  endfunction

  // Monitor / scoreboard: everything is stable here, half a cycle from the active edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] elig, exp_rdy, exp_rv;
    logic exp_mr;
    int c, g, id;
    bit mapped;
    ar_t a;
    beat_t bt;
    if (rst) begin
      chk("rst_s_arready", bus.s_arready, '0);
      busy = 1'b0; err_m = 1'b0; r_hs = 1'b0; ar_hs = '0;
      last_g = NREQ - 1;
      exp_ar.delete();
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] = 0; beatidx[i] = 0;
        exp_beat[i].delete();
        mem_pend[i].delete();
      end
    end else begin
      // arbitration: first eligible requester after the previous grant, when no AR pending
      for (int i = 0; i < NREQ; i++) elig[i] = bus.s_arvalid[i] && (cnt[i] < MAXO);
      exp_rdy = '0;
      g = -1;
      if (!busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (last_g + k) % NREQ;
          if (g < 0 && elig[c]) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("s_arready", bus.s_arready, exp_rdy);
      chk("m_arvalid", bus.m_arvalid, busy);
      if (bus.m_arvalid) begin
        if (exp_ar.size() == 0) begin
          errors++; checks++;
          $display("FAIL ar_unexpected: got m_arvalid=1 expected no pending AR");
        end else begin
          chk("m_araddr", bus.m_araddr, exp_ar[0].addr);
          chk("m_arlen", bus.m_arlen, exp_ar[0].len);
          chk("m_arid", bus.m_arid, IW'(exp_ar[0].id));
          if (bus.m_arready) begin
            a = exp_ar.pop_front();
            mem_pend[a.id].push_back(a);
            busy = 1'b0;
          end
        end
      end
      if (g >= 0) begin
        a.addr = bus.s_araddr[g*AW +: AW];
        a.len  = bus.s_arlen[g*LW +: LW];
        a.id   = g;
        exp_ar.push_back(a);
        for (int b = 0; b <= int'(a.len); b++) begin
          bt.data = mkdata(a.addr, b);
          bt.last = (b == int'(a.len));
          bt.resp = mkresp(a.addr, b);
          exp_beat[g].push_back(bt);
        end
        cnt[g]++;
        busy   = 1'b1;
        last_g = g;
      end
      ar_hs = bus.s_arvalid & bus.s_arready;

      // R routing by RID
      mapped = int'(bus.m_rid) < NREQ;
      exp_rv = '0;
      exp_mr = 1'b1;
      if (bus.m_rvalid && mapped) begin
        exp_rv[int'(bus.m_rid)] = 1'b1;
        exp_mr = bus.s_rready[int'(bus.m_rid)];
      end
      chk("s_rvalid", bus.s_rvalid, exp_rv);
      if (bus.m_rvalid) chk("m_rready", bus.m_rready, exp_mr);
      chk("rid_err", rid_err, err_m);
      if (bus.m_rvalid && !mapped) err_m = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.s_rvalid[i] && bus.s_rready[i]) begin
          if (exp_beat[i].size() == 0) begin
            errors++; checks++;
            $display("FAIL r_unexpected: got beat for requester %0d expected none", i);
          end else begin
            bt = exp_beat[i].pop_front();
            chk("s_rdata", bus.s_rdata, bt.data);
            chk("s_rlast", bus.s_rlast, bt.last);
            chk("s_rresp", bus.s_rresp, bt.resp);
            if (bt.last && cnt[i] > 0) cnt[i]--;
          end
        end
      end
      if (bus.m_rvalid && bus.m_rready && mapped) begin
        id = int'(bus.m_rid);
        beatidx[id]++;
        if (mem_pend[id].size() > 0 && beatidx[id] > int'(mem_pend[id][0].len)) begin
          void'(mem_pend[id].pop_front());
          beatidx[id] = 0;
        end
      end
      r_hs = bus.m_rvalid && bus.m_rready;
    end
  end

  task automatic run_cycles(input int n, input int p_ar, input int p_mar, input int p_mr);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.s_arvalid[i] && !ar_hs[i])) begin
          bus.s_arvalid[i] = ($urandom_range(99) < p_ar);
          bus.s_araddr[i*AW +: AW] = $urandom & 32'hffff_fff0;
          bus.s_arlen[i*LW +: LW]  = LW'($urandom_range(3));
        end
        bus.s_rready[i] = ($urandom_range(99) < 75);
      end
      bus.m_arready = ($urandom_range(99) < p_mar);
      if (!(bus.m_rvalid && !r_hs)) begin
        bus.m_rvalid = 1'b0;
        if ($urandom_range(99) < p_mr) begin
          int s;
          s = $urandom_range(NREQ - 1);
          for (int k = 0; k < NREQ; k++) begin
            int id;
            id = (s + k) % NREQ;
            if (!bus.m_rvalid && mem_pend[id].size() > 0) begin
              bus.m_rvalid = 1'b1;
              bus.m_rid    = IW'(id);
              bus.m_rdata  = mkdata(mem_pend[id][0].addr, beatidx[id]);
              bus.m_rresp  = mkresp(mem_pend[id][0].addr, beatidx[id]);
              bus.m_rlast  = (beatidx[id] == int'(mem_pend[id][0].len));
            end
          end
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_ar.size() > 0 || exp_beat[0].size() > 0 || exp_beat[1].size() > 0 ||
            bus.s_arvalid != '0) && n < 2000) begin
      run_cycles(1, 0, 100, 90);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d ARs and %0d/%0d beats pending expected 0",
               exp_ar.size(), exp_beat[0].size(), exp_beat[1].size());
    end
  endtask

  task automatic do_reset(input int cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.s_arvalid = '0; bus.m_rvalid = 1'b0; bus.m_arready = 1'b0;
    repeat (cyc) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic inject(input logic [IW-1:0] rid);
    @(posedge clk); #1;
    bus.m_rvalid = 1'b1; bus.m_rid = rid; bus.m_rlast = 1'b1;
    bus.m_rdata = 64'h0bad_0bad_0bad_0bad; bus.m_rresp = 2'b10;
    @(posedge clk); #1;
    bus.m_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_rready = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rlast = 1'b0;
    bus.m_rresp = 2'b00; bus.m_rid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_m_araddr", bus.m_araddr, '0);
    chk("rst_m_arlen", bus.m_arlen, '0);
    chk("rst_m_arid", bus.m_arid, '0);
    chk("rst_rid_err", rid_err, 1'b0);
    #1 rst = 1'b0;

    run_cycles(400, 60, 70, 60);
    run_cycles(60, 90, 90, 0);     // memory silent: counters reach the cap
    run_cycles(12, 90, 0, 50);     // AR held in ADDR while memory stalls
    run_cycles(400, 70, 60, 70);
    drain();

    inject(6'd3);
    inject(6'd2);
    inject(6'h20);
    run_cycles(20, 60, 70, 60);
    drain();

    run_cycles(20, 90, 90, 0);     // build outstanding bursts
    run_cycles(4, 90, 0, 0);       // leave an AR parked in ADDR
    do_reset(2);
    @(negedge clk);
    chk("post_rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("post_rst_rid_err", rid_err, 1'b0);

    run_cycles(300, 70, 70, 60);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
